// File: rtl/sample_pack_pkg.sv
// Shared definitions for the sample pack buffer: default geometry,
// derived widths and a clog2 helper that never returns zero.
package sample_pack_pkg;

  localparam int DEF_SAMPLE_W  = 12;
  localparam int DEF_PACK      = 4;
  localparam int DEF_DEPTH     = 512;
  localparam int DEF_AF_THRESH = 448;

  // Bit width needed to index 'value' items; at least 1 so that
  // degenerate sizes still give a legal vector.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  localparam int WORD_W = DEF_SAMPLE_W * DEF_PACK;
  localparam int NS_W   = clog2_safe(DEF_PACK + 1);
  localparam int LVL_W  = clog2_safe(DEF_DEPTH + 3);

endpackage

// File: rtl/spb_ram.sv
// Simple dual-port RAM with one write port and a registered read port,
// written so synthesis maps it onto a block RAM.
module spb_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store a committed word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: one-cycle synchronous read, no reset so it stays BRAM friendly.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_pack_buffer.sv
// Packs PACK samples per word into a RAM-backed buffer and serves the
// words on a valid/ready port through a two-entry output stage.
module sample_pack_buffer
  import sample_pack_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int PACK      = DEF_PACK,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [SAMPLE_W-1:0]                in_data,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SAMPLE_W*PACK-1:0]           out_data,
  output logic [clog2_safe(PACK+1)-1:0]      out_nsamp,
  output logic [clog2_safe(DEPTH+3)-1:0]     level,
  output logic                               almost_full,
  output logic                               overflow,
  input  logic                               clear_ovf
);

  localparam int DW  = SAMPLE_W * PACK;
  localparam int NSW = clog2_safe(PACK + 1);
  localparam int LVW = clog2_safe(DEPTH + 3);
  localparam int AW  = clog2_safe(DEPTH);
  localparam int CW  = clog2_safe(DEPTH + 1);
  localparam int LNW = clog2_safe(PACK);
  localparam int EW  = DW + NSW;

  logic [LNW-1:0] lane;
  logic [DW-1:0]  pack_reg;
  logic           flush_pending;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  ram_count;
  logic [1:0]     occ;
  logic           rd_pending;
  logic [DW-1:0]  head_data, tail_data;
  logic [NSW-1:0] head_ns, tail_ns;
  logic [EW-1:0]  ram_q;

  logic           ram_full, last_lane, accept, full_commit, flush_req, commit;
  logic           pop, rd_issue;
  logic [NSW-1:0] fill_cnt;
  logic [DW-1:0]  cur_word, commit_word;

  // Packer decisions: acceptance, the word being built and when it commits.
  always_comb begin
    ram_full    = (ram_count == CW'(DEPTH));
    last_lane   = (lane == LNW'(PACK - 1));
    in_ready    = !flush_pending && (!last_lane || !ram_full);
    accept      = in_valid && in_ready;
    fill_cnt    = NSW'(lane) + NSW'(accept);
    cur_word    = pack_reg;
    if (accept) cur_word[lane*SAMPLE_W +: SAMPLE_W] = in_data;
    commit_word = '0;
    for (int k = 0; k < PACK; k++) begin
      if (NSW'(k) < fill_cnt) commit_word[k*SAMPLE_W +: SAMPLE_W] = cur_word[k*SAMPLE_W +: SAMPLE_W];
    end
    full_commit = accept && last_lane;
    flush_req   = flush_pending || (flush && (fill_cnt != '0));
    commit      = full_commit || (flush_req && !ram_full);
  end

  // Output handshake and read issue; a pop this cycle frees a stage slot.
  always_comb begin
    out_valid   = (occ != 2'd0);
    pop         = out_valid && out_ready;
    rd_issue    = (ram_count != '0) &&
                  (({1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop}) < 3'd2);
    out_data    = head_data;
    out_nsamp   = head_ns;
    almost_full = (level >= LVW'(AF_THRESH));
  end

  // Lane counter, pack register and a flush held while the RAM is full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane          <= '0;
      pack_reg      <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (commit)      lane <= '0;
      else if (accept) lane <= lane + LNW'(1);
      if (accept) pack_reg <= cur_word;
      flush_pending <= flush_req && !commit;
    end
  end

  spb_ram #(.WIDTH(EW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (commit),
    .waddr (wr_ptr),
    .wdata ({fill_cnt, commit_word}),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // RAM pointers, occupancy and committed-word level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_count  <= '0;
      rd_pending <= 1'b0;
      level      <= '0;
    end else begin
      if (commit)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      ram_count  <= ram_count + CW'(commit) - CW'(rd_issue);
      rd_pending <= rd_issue;
      level      <= level + LVW'(commit) - LVW'(pop);
    end
  end

  // Two-entry output stage; the head drives out_* and stays put until popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_ns   <= '0;
      tail_data <= '0;
      tail_ns   <= '0;
    end else begin
      if (pop) begin
        if (occ == 2'd2) begin
          head_data <= tail_data;
          head_ns   <= tail_ns;
          if (rd_pending) {tail_ns, tail_data} <= ram_q;
        end else if (rd_pending) begin
          {head_ns, head_data} <= ram_q;
        end
      end else if (rd_pending) begin
        if (occ == 2'd0) {head_ns, head_data} <= ram_q;
        else             {tail_ns, tail_data} <= ram_q;
      end
      occ <= occ - 2'(pop) + 2'(rd_pending);
    end
  end

  // Sticky overflow; a new refused sample beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
    else if (clear_ovf)            overflow <= 1'b0;
  end

endmodule
